dmem_port: RTL and testbench



---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_ram.sv | 32 +++
 rtl/dmem_port.sv | 136 +++++++++++++
 tb/tb_dmem_port.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: funct3 width codes,
// FSM state encoding and byte-lane count.
package dmem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam int BE_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_e;

endpackage

// File: rtl/dmem_ram.sv
// Single-port word RAM with per-byte write enables and a registered read.
// Contents are not reset.
module dmem_ram
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic              re_i,
   input  logic [BE_W-1:0]   be_i,
   input  logic [IDX_W-1:0]  idx_i,
   input  logic [31:0]       wdata_i,
   output logic [31:0]       rdata_o
);

   logic [31:0] mem_q [DEPTH_WORDS];
   logic [31:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) begin
         for (int i = 0; i < BE_W; i++) begin
            if (be_i[i]) mem_q[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
         end
      end
      if (re_i) rdata_q <= mem_q[idx_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_port.sv
// Data-memory responder: IDLE/ACCESS/RESP handshake, store lane formatting and
// load extension. Define DMEM_MISALIGN_CHECK_EN to flag misaligned H/W accesses.
module dmem_port
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int ADDR_W      = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en_dmem,
   input  logic              load_store,
   input  logic [2:0]        funct3_dmem,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic              ready,
   output logic              busy,
   output logic              resp_valid,
   output logic [31:0]       rdata,
   output logic              resp_err
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);

   state_e              state_q, state_d;
   logic                ls_q;
   logic [2:0]          f3_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [31:0]         wdata_q;

   logic                f3_legal, is_half, is_word, misalign, err;
   logic [1:0]          off;
   logic [BE_W-1:0]     be;
   logic [31:0]         wlanes, ram_rdata, ext;
   logic [7:0]          byte_sel;
   logic [15:0]         half_sel;
   logic                ram_we, ram_re;
   logic                unused_addr_bits;

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Request fields are held from acceptance until the next IDLE.
   always_ff @(posedge clk) begin
      if (state_q == ST_IDLE && en_dmem) begin
         ls_q    <= load_store;
         f3_q    <= funct3_dmem;
         addr_q  <= addr;
         wdata_q <= wdata;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:   if (en_dmem) state_d = ST_ACCESS;
         ST_ACCESS: state_d = ST_RESP;
         ST_RESP:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      f3_legal = ls_q ? (f3_q inside {F3_B, F3_H, F3_W})
                      : (f3_q inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
      is_half  = (f3_q == F3_H) || (f3_q == F3_HU);
      is_word  = (f3_q == F3_W);
`ifdef DMEM_MISALIGN_CHECK_EN
      misalign = (is_half && addr_q[0]) || (is_word && (addr_q[1:0] != 2'b00));
      off      = addr_q[1:0];
`else
      // Misaligned halfword/word accesses round down to their natural boundary.
      misalign = 1'b0;
      off      = is_word ? 2'b00 : (is_half ? {addr_q[1], 1'b0} : addr_q[1:0]);
`endif
      err      = !f3_legal || misalign;
   end

   always_comb begin
      be     = '0;
      wlanes = wdata_q;
      case (f3_q)
         F3_B: begin
            be     = 4'b0001 << off;
            wlanes = {4{wdata_q[7:0]}};
         end
         F3_H: begin
            be     = off[1] ? 4'b1100 : 4'b0011;
            wlanes = {2{wdata_q[15:0]}};
         end
         F3_W:    be = 4'b1111;
         default: be = '0;
      endcase
   end

   // Reset in ACCESS must not let the write land.
   assign ram_we = (state_q == ST_ACCESS) && ls_q && !err && !rst;
   assign ram_re = (state_q == ST_ACCESS);

   dmem_ram #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .IDX_W       (IDX_W)
   ) u_ram (
      .clk     (clk),
      .we_i    (ram_we),
      .re_i    (ram_re),
      .be_i    (be),
      .idx_i   (addr_q[2 +: IDX_W]),
      .wdata_i (wlanes),
      .rdata_o (ram_rdata)
   );

   always_comb begin
      byte_sel = ram_rdata[{off, 3'b000} +: 8];
      half_sel = off[1] ? ram_rdata[31:16] : ram_rdata[15:0];
      case (f3_q)
         F3_B:    ext = {{24{byte_sel[7]}}, byte_sel};
         F3_BU:   ext = {24'd0, byte_sel};
         F3_H:    ext = {{16{half_sel[15]}}, half_sel};
         F3_HU:   ext = {16'd0, half_sel};
         F3_W:    ext = ram_rdata;
         default: ext = '0;
      endcase
   end

   assign busy       = (state_q != ST_IDLE);
   assign ready      = (state_q == ST_IDLE);
   assign resp_valid = (state_q == ST_RESP) && !rst;
   assign resp_err   = resp_valid && err;
   assign rdata      = (resp_valid && !ls_q && !err) ? ext : 32'd0;

   assign unused_addr_bits = ^addr_q[ADDR_W-1:IDX_W+2];

endmodule

// File: tb/tb_dmem_port.sv
// Scoreboard bench for dmem_port: a byte-level memory model predicts each
// response; honours DMEM_MISALIGN_CHECK_EN the same way the design does.
module tb_dmem_port;

   localparam int DEPTH = 1024;
   localparam int BYTES = DEPTH * 4;

   typedef struct packed {
      logic [31:0] rd;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        en_dmem;
   logic        load_store;
   logic [2:0]  funct3_dmem;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        ready, busy, resp_valid, resp_err;
   logic [31:0] rdata;

   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];
   logic [7:0] bmem [BYTES];

   always #5 clk = ~clk;

   dmem_port #(.DEPTH_WORDS(DEPTH), .ADDR_W(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .en_dmem     (en_dmem),
      .load_store  (load_store),
      .funct3_dmem (funct3_dmem),
      .addr        (addr),
      .wdata       (wdata),
      .ready       (ready),
      .busy        (busy),
      .resp_valid  (resp_valid),
      .rdata       (rdata),
      .resp_err    (resp_err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // Byte-addressed reference: returns expected response and updates bmem on stores.
   function automatic exp_t model(input logic ls, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] wd);
      exp_t e;
      int sz, base;
      bit sgn;
      logic [31:0] v;
      e = '0;
      sz = 0;
      sgn = 1'b0;
      case (f3)
         3'b000: begin sz = 1; sgn = 1'b1; end
         3'b001: begin sz = 2; sgn = 1'b1; end
         3'b010: sz = 4;
         3'b100: if (!ls) sz = 1;
         3'b101: if (!ls) sz = 2;
         default: sz = 0;
      endcase
      if (sz == 0) begin
         e.err = 1'b1;
         return e;
      end
      base = int'(a % BYTES);
`ifdef DMEM_MISALIGN_CHECK_EN
      if (base % sz != 0) begin
         e.err = 1'b1;
         return e;
      end
`else
      base = base - (base % sz);
`endif
      if (ls) begin
         for (int i = 0; i < sz; i++) bmem[base + i] = wd[8*i +: 8];
      end else begin
         v = '0;
         for (int i = 0; i < sz; i++) v[8*i +: 8] = bmem[base + i];
         if (sgn && sz == 1) v = {{24{v[7]}}, v[7:0]};
         if (sgn && sz == 2) v = {{16{v[15]}}, v[15:0]};
         e.rd = v;
      end
      return e;
   endfunction

   always @(negedge clk) begin
      if (resp_valid === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_resp", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("rdata", rdata, e.rd);
            check("resp_err", {31'd0, resp_err}, {31'd0, e.err});
         end
      end
   end

   task automatic drive(input logic ls, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
      load_store  = ls;
      funct3_dmem = f3;
      addr        = a;
      wdata       = wd;
   endtask

   // One request with full latency checks: busy in ACCESS, resp_valid in RESP.
   task automatic do_req(input logic ls, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
      int n;
      @(negedge clk);
      en_dmem = 1'b1;
      drive(ls, f3, a, wd);
      n = 0;
      while (!ready && n < 10) begin
         @(negedge clk);
         n++;
      end
      if (!ready) check("ready_timeout", 32'd0, 32'd1);
      @(posedge clk);
      sb.push_back(model(ls, f3, a, wd));
      @(negedge clk);
      en_dmem = 1'b0;
      check("busy_access", {31'd0, busy}, 32'd1);
      check("no_early_resp", {31'd0, resp_valid}, 32'd0);
      @(negedge clk);
      check("resp_latency", {31'd0, resp_valid}, 32'd1);
   endtask

   initial begin
      int n, busycnt;
      logic [2:0] f3tab [7];
      f3tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110};
      rst = 1'b1;
      en_dmem = 1'b0;
      drive(1'b0, 3'b000, 32'd0, 32'd0);
      repeat (3) @(negedge clk);
      check("rst_ready", {31'd0, ready}, 32'd1);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_valid", {31'd0, resp_valid}, 32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_err", {31'd0, resp_err}, 32'd0);
      rst = 1'b0;

      do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
      do_req(1'b0, 3'b010, 32'h10, 32'h0);
      do_req(1'b1, 3'b000, 32'h13, 32'h00000080);
      do_req(1'b0, 3'b000, 32'h13, 32'h0);
      do_req(1'b0, 3'b100, 32'h13, 32'h0);
      do_req(1'b0, 3'b010, 32'h10, 32'h0);
      do_req(1'b1, 3'b001, 32'h12, 32'h00001234);
      do_req(1'b0, 3'b001, 32'h12, 32'h0);
      do_req(1'b0, 3'b101, 32'h10, 32'h0);
      do_req(1'b0, 3'b010, 32'h11, 32'h0);
      do_req(1'b1, 3'b010, 32'h11, 32'hCAFEF00D);
      do_req(1'b0, 3'b010, 32'h10, 32'h0);
      do_req(1'b0, 3'b001, 32'h11, 32'h0);
      do_req(1'b1, 3'b001, 32'h13, 32'h0000A5C3);
      do_req(1'b0, 3'b010, 32'h10, 32'h0);
      do_req(1'b1, 3'b011, 32'h10, 32'h11111111);
      do_req(1'b1, 3'b100, 32'h10, 32'h22222222);
      do_req(1'b0, 3'b010, 32'h10, 32'h0);
      do_req(1'b0, 3'b011, 32'h10, 32'h0);
      do_req(1'b0, 3'b111, 32'h10, 32'h0);
      do_req(1'b1, 3'b010, 32'h10 + BYTES, 32'h0BADF00D);
      do_req(1'b0, 3'b010, 32'h10, 32'h0);

      for (int w = 0; w < 16; w++) do_req(1'b1, 3'b010, 32'h40 + 4*w, $urandom);
      for (int k = 0; k < 24; k++)
         do_req(1'($urandom_range(0, 1)), f3tab[$urandom_range(0, 6)],
                32'h40 + $urandom_range(0, 63), $urandom);

      // en_dmem held high across two requests.
      @(negedge clk);
      en_dmem = 1'b1;
      drive(1'b1, 3'b010, 32'h30, 32'h5A5AC3C3);
      @(posedge clk);
      sb.push_back(model(1'b1, 3'b010, 32'h30, 32'h5A5AC3C3));
      @(negedge clk);
      drive(1'b0, 3'b010, 32'h30, 32'h0);
      n = 0;
      busycnt = 0;
      while (!ready && n < 10) begin
         if (busy) busycnt++;
         n++;
         @(negedge clk);
      end
      check("b2b_wait", n, 32'd2);
      check("b2b_busy_cycles", busycnt, 32'd2);
      @(posedge clk);
      sb.push_back(model(1'b0, 3'b010, 32'h30, 32'h0));
      @(negedge clk);
      en_dmem = 1'b0;
      check("b2b_second_busy", {31'd0, busy}, 32'd1);
      repeat (2) @(negedge clk);

      // Reset during ACCESS: store dropped, no response.
      do_req(1'b1, 3'b010, 32'h20, 32'h11223344);
      @(negedge clk);
      en_dmem = 1'b1;
      drive(1'b1, 3'b010, 32'h20, 32'h55667788);
      @(posedge clk);
      @(negedge clk);
      en_dmem = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_ready", {31'd0, ready}, 32'd1);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_valid", {31'd0, resp_valid}, 32'd0);
      check("abort_rdata", rdata, 32'd0);
      check("abort_err", {31'd0, resp_err}, 32'd0);
      @(negedge clk);
      check("abort_no_pulse", {31'd0, resp_valid}, 32'd0);
      do_req(1'b0, 3'b010, 32'h20, 32'h0);

      repeat (3) @(negedge clk);
      check("sb_drain", sb.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=running expected=finished");
      $fatal(1);
   end

endmodule
